return_stream_arbiter: RTL

- Shares the single return-FIFO byte-packing port between NUM_REQ compressor lanes.
- Grants one lane at a time, for a whole packet, in round-robin order.
- Muxes the granted lane's bytes and valid count onto the FIFO port and routes the FIFO's shift back to that lane only.
- At packet end, drives the end-of-stream flush window, then re-arbitrates.

---
 rtl/return_stream_arbiter_pkg.sv | 25 ++
 rtl/return_stream_arbiter_if.sv | 21 ++
 rtl/return_stream_arbiter_rr_picker.sv | 18 +
 rtl/return_stream_arbiter.sv | 107 ++++++++++
 4 files changed

// File: rtl/return_stream_arbiter_pkg.sv
// Shared types and helpers for the return-stream arbiter: FSM states, width
// defaults and the round-robin scan function.
package return_arb_pkg;
  localparam int NUM_REQ      = 4;
  localparam int IN_BYTES     = 16;
  localparam int MAX_ELEMENTS = 34;
  localparam int CNT_W        = $clog2(MAX_ELEMENTS);
  localparam int GID_W        = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, GRANT, FLUSH} arb_state_t;

  // Returns {found, index}. The scan walks from farthest to nearest, so the
  // lane closest after ptr is the one left in the result.
  function automatic logic [3:0] rr_next(input logic [7:0] req_vec,
                                         input logic [2:0] ptr, input int n);
    int j;
    rr_next = '0;
    for (int k = 8; k >= 1; k--) begin
      if (k <= n) begin
        j = (int'(ptr) + k) % n;
        if (req_vec[j]) rr_next = {1'b1, j[2:0]};
      end
    end
  endfunction
endpackage

// File: rtl/return_stream_arbiter_if.sv
// Lane-side and FIFO-side byte-packing signals of the return-stream arbiter.
// master = arbiter, slave = lanes plus return FIFO.
interface return_stream_arbiter_if #(
  parameter int NUM_REQ  = return_arb_pkg::NUM_REQ,
  parameter int IN_BYTES = return_arb_pkg::IN_BYTES,
  parameter int CNT_W    = return_arb_pkg::CNT_W
);
  logic [NUM_REQ-1:0][IN_BYTES-1:0][7:0] req_data;
  logic [NUM_REQ-1:0][CNT_W-1:0]         req_bytes_valid;
  logic [NUM_REQ-1:0]                    req_last;
  logic [NUM_REQ-1:0]                    req_shift;
  logic [IN_BYTES-1:0][7:0]              fifo_data;
  logic [CNT_W-1:0]                      fifo_bytes_valid;
  logic                                  fifo_shift;
  logic                                  fifo_eos;

  modport master (input req_data, req_bytes_valid, req_last, fifo_shift,
                  output req_shift, fifo_data, fifo_bytes_valid, fifo_eos);
  modport slave  (output req_data, req_bytes_valid, req_last, fifo_shift,
                  input req_shift, fifo_data, fifo_bytes_valid, fifo_eos);
endinterface

// File: rtl/return_stream_arbiter_rr_picker.sv
// Combinational round-robin select: first requesting lane after ptr, with wrap.
module rr_picker #(
  parameter int NUM_REQ = return_arb_pkg::NUM_REQ,
  parameter int GID_W   = return_arb_pkg::GID_W
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GID_W-1:0]   ptr,
  output logic               found,
  output logic [GID_W-1:0]   idx
);
  import return_arb_pkg::rr_next;

  logic [3:0] pick;

  assign pick  = rr_next(8'(req), 3'(ptr), NUM_REQ);
  assign found = pick[3];
  assign idx   = GID_W'(pick[2:0]);
endmodule

// File: rtl/return_stream_arbiter.sv
// Round-robin, packet-granular arbiter sharing the return-FIFO packing port.
// Optional stall watchdog under `define RSA_WATCHDOG_EN.
module return_stream_arbiter #(
  parameter int NUM_REQ         = return_arb_pkg::NUM_REQ,
  parameter int IN_BYTES        = return_arb_pkg::IN_BYTES,
  parameter int MAX_ELEMENTS    = return_arb_pkg::MAX_ELEMENTS,
  parameter int FLUSH_CYCLES    = 2,
  parameter int WATCHDOG_CYCLES = 256,
  localparam int CNT_W          = $clog2(MAX_ELEMENTS),
  localparam int GID_W          = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  return_stream_arbiter_if.master bus,
  output logic [GID_W-1:0]       grant_id,
  output logic                   busy
`ifdef RSA_WATCHDOG_EN
  , output logic                 wd_fired
`endif
);
  import return_arb_pkg::*;

  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W:0] WIN_BYTES = (CNT_W + 1)'(IN_BYTES);

  arb_state_t         state, state_nxt;
  logic [GID_W-1:0]   rr_ptr, pick_idx;
  logic               pick_found;
  logic [NUM_REQ-1:0] req_vec;
  logic [FW-1:0]      flush_cnt;
  logic [CNT_W-1:0]   g_bv;
  logic               pkt_end, wd_hit;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign req_vec[i] = |bus.req_bytes_valid[i];
  end

  rr_picker #(.NUM_REQ(NUM_REQ), .GID_W(GID_W)) u_pick (
    .req(req_vec), .ptr(rr_ptr), .found(pick_found), .idx(pick_idx)
  );

  assign g_bv = bus.req_bytes_valid[grant_id];
  // A window flagged last but wider than one beat still has bytes behind it.
  assign pkt_end = (state == GRANT) && bus.fifo_shift && bus.req_last[grant_id] &&
                   ({1'b0, g_bv} <= WIN_BYTES);
  assign busy = (state != IDLE);

`ifdef RSA_WATCHDOG_EN
  localparam int SW = $clog2(WATCHDOG_CYCLES + 1);
  logic [SW-1:0] stall_cnt;

  assign wd_hit = (state == GRANT) && (g_bv == '0) &&
                  (stall_cnt == SW'(WATCHDOG_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      wd_fired  <= 1'b0;
    end else begin
      wd_fired  <= wd_hit;
      stall_cnt <= (state == GRANT && g_bv == '0 && !wd_hit) ? stall_cnt + 1'b1 : '0;
    end
  end
`else
  assign wd_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant_id  <= '0;
      rr_ptr    <= GID_W'(NUM_REQ - 1);
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      // rr_ptr tracks the lane just served, so it ranks last next time round.
      if (state == IDLE && pick_found) begin
        grant_id <= pick_idx;
        rr_ptr   <= pick_idx;
      end
      if (pkt_end || wd_hit)  flush_cnt <= FW'(FLUSH_CYCLES - 1);
      else if (state == FLUSH) flush_cnt <= flush_cnt - 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_found)          state_nxt = GRANT;
      GRANT:   if (pkt_end || wd_hit)   state_nxt = FLUSH;
      FLUSH:   if (flush_cnt == '0)     state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.fifo_data        = '0;
    bus.fifo_bytes_valid = '0;
    bus.req_shift        = '0;
    bus.fifo_eos         = (state == FLUSH);
    if (state == GRANT) begin
      bus.fifo_data           = bus.req_data[grant_id];
      bus.fifo_bytes_valid    = g_bv;
      bus.req_shift[grant_id] = bus.fifo_shift;
    end
  end
endmodule
